// File: rtl/yc_pkg.sv
// Shared definitions for the YC encoder back end: line states, default
// video levels/gains and the 8-bit output clamp.
package yc_pkg;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_PORCH,
    ST_BURST,
    ST_BLANK,
    ST_ACTIVE
  } line_st_t;

  localparam logic [7:0]  SYNC_LVL_D    = 8'd0;
  localparam logic [7:0]  BLANK_LVL_D   = 8'd72;
  localparam logic [7:0]  SETUP_LVL_D   = 8'd10;
  localparam logic [8:0]  Y_GAIN_D      = 9'd183;
  localparam logic [8:0]  C_GAIN_D      = 9'd128;
  localparam logic [11:0] BURST_START_D = 12'd40;
  localparam logic [11:0] BURST_END_D   = 12'd240;

  function automatic logic [7:0] sat8(input logic signed [10:0] v);
    if (v < 11'sd0)
      return 8'd0;
    else if (v > 11'sd255)
      return 8'd255;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/yc_sat_scale.sv
// Signed operand times unsigned gain, arithmetic shift by 8, two register
// stages; the second stage can be forced to zero by the gate input.
module yc_sat_scale #(
  parameter logic [8:0] GAIN = 9'd128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic signed [8:0] operand,
  input  logic              gate,
  output logic signed [9:0] result
);

  logic signed [18:0] op_x;
  logic signed [18:0] gain_x;
  logic signed [18:0] prod;

  assign op_x   = {{10{operand[8]}}, operand};
  assign gain_x = {10'd0, GAIN};

  // Product fits in 18 bits for any 9-bit gain, so [17:8] is the >>>8 result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod   <= '0;
      result <= '0;
    end else begin
      prod   <= op_x * gain_x;
      result <= gate ? prod[17:8] : 10'sd0;
    end
  end

endmodule

// File: rtl/yc_cvbs_mix.sv
// Composite mixer: adds sync/blank/setup levels to luma, gates chroma to
// burst and active video, and sums both into a clamped CVBS word.
module yc_cvbs_mix
  import yc_pkg::*;
#(
  parameter logic [7:0]  SYNC_LVL    = SYNC_LVL_D,
  parameter logic [7:0]  BLANK_LVL   = BLANK_LVL_D,
  parameter logic [7:0]  SETUP_LVL   = SETUP_LVL_D,
  parameter logic [8:0]  Y_GAIN      = Y_GAIN_D,
  parameter logic [8:0]  C_GAIN      = C_GAIN_D,
  parameter logic [11:0] BURST_START = BURST_START_D,
  parameter logic [11:0] BURST_END   = BURST_END_D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pal_en,
  input  logic [23:0] din,
  input  logic        de_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        csync_i,
  output logic [23:0] dout,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        csync_o
);

  line_st_t    state, state_nxt, st2;
  logic [11:0] pos_cnt, pos_nxt;
  logic        vs1, pal1, pal2, chroma_en;
  logic [2:0]  hs_pipe, vs_pipe, cs_pipe;
  logic signed [8:0] y_op, c_op;
  logic signed [9:0] y_s, c_s;
  logic [9:0]  lvl;
  logic signed [10:0] cvbs_sum, c_sum;
  logic        unused_din;

  assign unused_din = ^din[7:0];

  // The state register holds the class of the pixel now in stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_BLANK;
      pos_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pos_cnt <= pos_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos_cnt;
    if (csync_i) begin
      state_nxt = ST_SYNC;
      pos_nxt   = '0;
    end else begin
      if (state != ST_SYNC && pos_cnt != 12'hFFF)
        pos_nxt = pos_cnt + 12'd1;
      if (state == ST_SYNC)
        state_nxt = ST_PORCH;
      else if (state == ST_PORCH && pos_cnt == BURST_START - 12'd1)
        state_nxt = ST_BURST;
      else if (state == ST_BURST && pos_cnt == BURST_END)
        state_nxt = ST_BLANK;
      else if (de_i && (state == ST_PORCH || state == ST_BURST || state == ST_BLANK))
        state_nxt = ST_ACTIVE;
      else if (state == ST_ACTIVE && !de_i)
        state_nxt = ST_BLANK;
    end
  end

  assign y_op      = $signed({1'b0, din[15:8]});
  assign c_op      = $signed({1'b0, din[23:16]}) - 9'sd128;
  assign chroma_en = (state == ST_BURST && !vs1) || state == ST_ACTIVE;

  yc_sat_scale #(.GAIN(Y_GAIN)) u_y_scale (
    .clk(clk), .rst_n(rst_n), .operand(y_op), .gate(1'b1), .result(y_s)
  );

  yc_sat_scale #(.GAIN(C_GAIN)) u_c_scale (
    .clk(clk), .rst_n(rst_n), .operand(c_op), .gate(chroma_en), .result(c_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs1     <= 1'b0;
      pal1    <= 1'b0;
      pal2    <= 1'b0;
      st2     <= ST_BLANK;
      hs_pipe <= '0;
      vs_pipe <= '0;
      cs_pipe <= '0;
    end else begin
      vs1     <= vsync_i;
      pal1    <= pal_en;
      pal2    <= pal1;
      st2     <= state;
      hs_pipe <= {hs_pipe[1:0], hsync_i};
      vs_pipe <= {vs_pipe[1:0], vsync_i};
      cs_pipe <= {cs_pipe[1:0], csync_i};
    end
  end

  always_comb begin
    lvl = {2'b00, BLANK_LVL};
    if (st2 == ST_SYNC)
      lvl = {2'b00, SYNC_LVL};
    else if (st2 == ST_ACTIVE)
      lvl = {2'b00, BLANK_LVL} + (pal2 ? 10'd0 : {2'b00, SETUP_LVL}) + $unsigned(y_s);
  end

  assign cvbs_sum = $signed({1'b0, lvl}) + {c_s[9], c_s};
  assign c_sum    = 11'sd128 + {c_s[9], c_s};

  // The sync tip never carries chroma, whatever the gate says.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= {BLANK_LVL, BLANK_LVL, 8'd128};
    end else begin
      dout <= {(st2 == ST_SYNC) ? SYNC_LVL : sat8(cvbs_sum),
               sat8($signed({1'b0, lvl})), sat8(c_sum)};
    end
  end

  assign hsync_o = hs_pipe[2];
  assign vsync_o = vs_pipe[2];
  assign csync_o = cs_pipe[2];

endmodule

// File: tb/tb_yc_cvbs_mix.sv
// Self-checking bench for yc_cvbs_mix: a per-pixel level model predicts
// every output word three clocks ahead; directed literals pin the model.
module tb_yc_cvbs_mix;
  import yc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pal_en = 1'b0;
  logic [23:0] din = 24'hFFFF00;
  logic        de_i = 1'b0, hsync_i = 1'b0, vsync_i = 1'b0, csync_i = 1'b0;
  logic [23:0] dout, dout_g;
  logic        hsync_o, vsync_o, csync_o;
  logic        hsync_g, vsync_g, csync_g;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  yc_cvbs_mix dut (
    .clk(clk), .rst_n(rst_n), .pal_en(pal_en), .din(din), .de_i(de_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .csync_i(csync_i),
    .dout(dout), .hsync_o(hsync_o), .vsync_o(vsync_o), .csync_o(csync_o)
  );

  yc_cvbs_mix #(.C_GAIN(9'd256)) dut_g (
    .clk(clk), .rst_n(rst_n), .pal_en(pal_en), .din(din), .de_i(de_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .csync_i(csync_i),
    .dout(dout_g), .hsync_o(hsync_g), .vsync_o(vsync_g), .csync_o(csync_g)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] c, input logic [7:0] y, input logic de,
                               input logic vs, input logic cs, input int n);
    din     = {c, y, 8'h00};
    de_i    = de;
    vsync_i = vs;
    csync_i = cs;
    hsync_i = cs;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  // Pixel class: 0 sync tip, 1 back porch, 2 burst, 3 blank, 4 active picture.
  function automatic logic [23:0] pixelWord(input int phase, input logic [7:0] c,
                                            input logic [7:0] y, input logic vs,
                                            input logic pal, input int gain);
    int ys, cs, lvl, cvbs;
    bit chroma_on;
    ys = (int'(y) * 183) / 256;
    chroma_on = (phase == 2 && !vs) || phase == 4;
    cs = chroma_on ? (((int'(c) - 128) * gain) >>> 8) : 0;
    if (phase == 0)
      lvl = 0;
    else if (phase == 4)
      lvl = 72 + (pal ? 0 : 10) + ys;
    else
      lvl = 72;
    cvbs = (phase == 0) ? 0 : clamp8(lvl + cs);
    return {8'(cvbs), 8'(clamp8(lvl)), 8'(clamp8(128 + cs))};
  endfunction

  int          m_phase = 3;
  int          m_pos = 0;
  logic [23:0] e_d[3];
  logic [23:0] e_g[3];
  logic [2:0]  e_s[3];

  // Compare what is on the outputs now, then advance the model by the pixel
  // that the next rising edge will capture.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("reset_dout", 32'(dout), 32'h484880);
      checkOutput("reset_dout_g", 32'(dout_g), 32'h484880);
      checkOutput("reset_syncs", 32'({hsync_o, vsync_o, csync_o}), 32'h0);
      m_phase = 3;
      m_pos = 0;
      for (int i = 0; i < 3; i++) begin
        e_d[i] = 24'h484880;
        e_g[i] = 24'h484880;
        e_s[i] = 3'b000;
      end
    end else begin
      checkOutput("model_dout", 32'(dout), 32'(e_d[2]));
      checkOutput("model_dout_g", 32'(dout_g), 32'(e_g[2]));
      checkOutput("model_syncs", 32'({hsync_o, vsync_o, csync_o}), 32'(e_s[2]));
      checkOutput("model_pos", 32'(dut.pos_cnt), 32'(m_pos));
      if (csync_i) begin
        m_phase = 0;
        m_pos = 0;
      end else begin
        int prev_phase, prev_pos;
        prev_phase = m_phase;
        prev_pos = m_pos;
        if (prev_phase != 0 && m_pos < 4095)
          m_pos = m_pos + 1;
        if (prev_phase == 0)
          m_phase = 1;
        else if (prev_phase == 1 && prev_pos == 39)
          m_phase = 2;
        else if (prev_phase == 2 && prev_pos == 240)
          m_phase = 3;
        else if (de_i && prev_phase != 4)
          m_phase = 4;
        else if (prev_phase == 4 && !de_i)
          m_phase = 3;
      end
      e_d[2] = e_d[1];
      e_d[1] = e_d[0];
      e_d[0] = pixelWord(m_phase, din[23:16], din[15:8], vsync_i, pal_en, 128);
      e_g[2] = e_g[1];
      e_g[1] = e_g[0];
      e_g[0] = pixelWord(m_phase, din[23:16], din[15:8], vsync_i, pal_en, 256);
      e_s[2] = e_s[1];
      e_s[1] = e_s[0];
      e_s[0] = {hsync_i, vsync_i, csync_i};
    end
  end

  initial begin
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 5);
    rst_n = 1'b1;
    applyStimulus(8'd128, 8'd0, 1'b0, 1'b0, 1'b0, 4);

    applyStimulus(8'd200, 8'd100, 1'b0, 1'b0, 1'b1, 50);
    @(negedge clk);
    checkOutput("sync_tip", 32'(dout), 32'h000080);

    applyStimulus(8'd200, 8'd100, 1'b0, 1'b0, 1'b0, 20);
    @(negedge clk);
    checkOutput("porch_no_burst", 32'(dout), 32'h484880);
    applyStimulus(8'd200, 8'd100, 1'b0, 1'b0, 1'b0, 80);
    @(negedge clk);
    checkOutput("burst_on", 32'(dout), 32'h6C48A4);
    applyStimulus(8'd200, 8'd100, 1'b0, 1'b0, 1'b0, 200);
    @(negedge clk);
    checkOutput("burst_closed", 32'(dout), 32'h484880);

    applyStimulus(8'd200, 8'd100, 1'b0, 1'b0, 1'b1, 10);
    applyStimulus(8'd200, 8'd100, 1'b0, 1'b1, 1'b0, 100);
    @(negedge clk);
    checkOutput("burst_vsync_muted", 32'(dout), 32'h484880);

    applyStimulus(8'd200, 8'd100, 1'b0, 1'b0, 1'b1, 10);
    applyStimulus(8'd200, 8'd100, 1'b0, 1'b0, 1'b0, 100);
    applyStimulus(8'd56, 8'd128, 1'b1, 1'b0, 1'b0, 1);
    checkOutput("de_in_burst_state", 32'(dut.state), 32'(ST_ACTIVE));
    applyStimulus(8'd56, 8'd128, 1'b1, 1'b0, 1'b0, 10);
    @(negedge clk);
    checkOutput("active_ntsc", 32'(dout), 32'h89AD5C);

    pal_en = 1'b1;
    applyStimulus(8'd56, 8'd128, 1'b1, 1'b0, 1'b0, 5);
    @(negedge clk);
    checkOutput("active_pal", 32'(dout), 32'h7FA35C);
    pal_en = 1'b0;

    applyStimulus(8'd255, 8'd255, 1'b1, 1'b0, 1'b0, 5);
    @(negedge clk);
    checkOutput("sat_high_g256", 32'(dout_g), 32'hFFFFFF);
    checkOutput("sat_high_g128", 32'(dout), 32'hFFFFBF);
    applyStimulus(8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 5);
    @(negedge clk);
    checkOutput("sat_low_g256", 32'(dout_g), 32'h005200);
    checkOutput("sat_low_g128", 32'(dout), 32'h125240);

    applyStimulus(8'd56, 8'd128, 1'b1, 1'b0, 1'b0, 5);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_dout", 32'(dout), 32'h484880);
    applyStimulus(8'd56, 8'd128, 1'b0, 1'b0, 1'b0, 3);
    rst_n = 1'b1;

    applyStimulus(8'd90, 8'd50, 1'b0, 1'b0, 1'b0, 5000);
    @(negedge clk);
    checkOutput("pos_cnt_saturated", 32'(dut.pos_cnt), 32'd4095);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
